// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: word width, PC step, NOP encoding and the
// fetch FSM state type. The HOLD state only exists when FETCH_SKID_EN is
// defined.
package pipeline_pkg;

  localparam int          WORD_W    = 32;
  localparam logic [31:0] PC_STEP   = 32'd4;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_REQ     = 2'd0,
`ifdef FETCH_SKID_EN
    ST_HOLD    = 2'd2,
`endif
    ST_DISCARD = 2'd1
  } fetch_state_t;

  // Sequential PC successor; wraps modulo 2^32.
  function automatic logic [WORD_W-1:0] pc_plus_step(input logic [WORD_W-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry instruction skid buffer: captures a response that arrived while
// the decode register was stalled, so the memory request can be dropped.
module fetch_skid_buf
  import pipeline_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [WORD_W-1:0] word,
  output logic [WORD_W-1:0] held_word,
  output logic              full
);

  logic [WORD_W-1:0] word_reg;
  logic              full_reg;

  // Capture on load, empty on clear or reset; load wins if both are seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_reg <= INSTR_NOP;
      full_reg <= 1'b0;
    end else if (load) begin
      word_reg <= word;
      full_reg <= 1'b1;
    end else if (clear) begin
      word_reg <= INSTR_NOP;
      full_reg <= 1'b0;
    end
  end

  assign held_word = word_reg;
  assign full      = full_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage. Issues word-aligned requests at pc, delivers a
// response to IF_ID in the same cycle it arrives, and handles redirects that
// land while a request is still outstanding by dropping the stale response.
// Optional feature macro: FETCH_SKID_EN (adds a one-entry skid buffer and the
// HOLD state so a stalled response is kept instead of re-requested).
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemReady,
  input  logic [31:0] imemData,
  output logic [31:0] nextPcOUT,
  output logic [31:0] instruccionOUT,
  output logic        validOUT,
  output logic        flushOUT
);

  fetch_state_t      state_reg, state_next;
  logic [WORD_W-1:0] pc_reg, pc_next;
  logic [WORD_W-1:0] held_reg, held_next;
  logic [WORD_W-1:0] pc_step;
  logic              skid_load;
  logic              skid_clear;

  assign pc_step = pc_plus_step(pc_reg);

`ifdef FETCH_SKID_EN
  logic [WORD_W-1:0] skid_word;
  logic              skid_full;

  fetch_skid_buf u_skid (
    .clk       (clk),
    .reset     (reset),
    .load      (skid_load),
    .clear     (skid_clear),
    .word      (imemData),
    .held_word (skid_word),
    .full      (skid_full)
  );
`endif

  // State register: FSM state, program counter and the address of the
  // request whose response must be discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_REQ;
      pc_reg    <= RESET_PC;
      held_reg  <= RESET_PC;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      held_reg  <= held_next;
    end
  end

  // Next-state logic: redirect beats stall, stall beats delivery.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    held_next  = held_reg;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    case (state_reg)
      ST_REQ: begin
        if (branchTaken) begin
          pc_next = branchTarget;
          // Response still in flight: remember where it went and drop it later.
          if (!imemReady) begin
            held_next  = pc_reg;
            state_next = ST_DISCARD;
          end
        end else if (imemReady && !stall) begin
          pc_next = pc_step;
        end else if (imemReady && stall) begin
`ifdef FETCH_SKID_EN
          skid_load  = 1'b1;
          state_next = ST_HOLD;
`endif
        end
      end
      ST_DISCARD: begin
        if (branchTaken) pc_next = branchTarget;
        if (imemReady)   state_next = ST_REQ;
      end
`ifdef FETCH_SKID_EN
      ST_HOLD: begin
        if (branchTaken) begin
          pc_next    = branchTarget;
          skid_clear = 1'b1;
          state_next = ST_REQ;
        end else if (!stall) begin
          pc_next    = pc_step;
          skid_clear = 1'b1;
          state_next = ST_REQ;
        end
      end
`endif
      default: state_next = ST_REQ;
    endcase
  end

  // Output logic: request, delivery and flush; everything quiet in reset.
  always_comb begin
    imemReq        = 1'b0;
    imemAddr       = 32'h0;
    validOUT       = 1'b0;
    flushOUT       = 1'b0;
    nextPcOUT      = 32'h0;
    instruccionOUT = INSTR_NOP;
    if (!reset) begin
      case (state_reg)
        ST_REQ: begin
          imemReq  = 1'b1;
          imemAddr = pc_reg;
          if (branchTaken) begin
            flushOUT = 1'b1;
          end else if (imemReady && !stall) begin
            validOUT       = 1'b1;
            instruccionOUT = imemData;
            nextPcOUT      = pc_step;
          end
        end
        ST_DISCARD: begin
          imemReq  = 1'b1;
          imemAddr = held_reg;
          flushOUT = branchTaken;
        end
`ifdef FETCH_SKID_EN
        ST_HOLD: begin
          flushOUT = branchTaken;
          if (!branchTaken && !stall && skid_full) begin
            validOUT       = 1'b1;
            instruccionOUT = skid_word;
            nextPcOUT      = pc_step;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed vectors, a transaction-level model
// checked every cycle, and literal expectations at the interesting points.
`timescale 1ns/1ps
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branchTaken = 1'b0;
  logic [31:0] branchTarget = 32'h0;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady = 1'b0;
  logic [31:0] imemData = 32'h0;
  logic [31:0] nextPcOUT;
  logic [31:0] instruccionOUT;
  logic        validOUT;
  logic        flushOUT;

  int tests = 0;
  int fails = 0;
  bit running = 1'b1;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .branchTaken    (branchTaken),
    .branchTarget   (branchTarget),
    .imemReq        (imemReq),
    .imemAddr       (imemAddr),
    .imemReady      (imemReady),
    .imemData       (imemData),
    .nextPcOUT      (nextPcOUT),
    .instruccionOUT (instruccionOUT),
    .validOUT       (validOUT),
    .flushOUT       (flushOUT)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the fetch unit is either requesting, waiting to throw away one
  // stale response, or (skid build) sitting on one buffered instruction.
  logic [31:0] m_pc = 32'h0;
  bit          m_drop = 1'b0;
  logic [31:0] m_drop_addr = 32'h0;
  bit          m_buf_full = 1'b0;
  logic [31:0] m_buf = 32'h0;

  // Compare process: inputs change on negedge, outputs checked 2ns later,
  // then the model advances to what the next posedge must produce.
  always @(negedge clk) begin
    logic        e_req, e_valid, e_flush;
    logic [31:0] e_addr, e_npc, e_ins;
    #2;
    if (running) begin
      e_req = 0; e_valid = 0; e_flush = 0; e_addr = 0; e_npc = 0; e_ins = 0;
      if (reset) begin
        m_pc = 32'h0; m_drop = 0; m_buf_full = 0;
      end else if (m_buf_full) begin
        if (branchTaken) begin
          e_flush = 1; m_pc = branchTarget; m_buf_full = 0;
        end else if (!stall) begin
          e_valid = 1; e_ins = m_buf; e_npc = m_pc + 32'd4;
          m_pc = m_pc + 32'd4; m_buf_full = 0;
        end
      end else begin
        e_req  = 1;
        e_addr = m_drop ? m_drop_addr : m_pc;
        if (branchTaken) begin
          e_flush = 1;
          if (m_drop) begin
            if (imemReady) m_drop = 0;
          end else if (!imemReady) begin
            m_drop = 1; m_drop_addr = m_pc;
          end
          m_pc = branchTarget;
        end else if (m_drop) begin
          if (imemReady) m_drop = 0;
        end else if (imemReady && !stall) begin
          e_valid = 1; e_ins = imemData; e_npc = m_pc + 32'd4;
          m_pc = m_pc + 32'd4;
        end else if (imemReady && stall) begin
`ifdef FETCH_SKID_EN
          m_buf_full = 1; m_buf = imemData;
`endif
        end
      end
      chk("model_req", {31'b0, imemReq}, {31'b0, e_req});
      if (e_req) chk("model_addr", imemAddr, e_addr);
      chk("model_valid", {31'b0, validOUT}, {31'b0, e_valid});
      chk("model_flush", {31'b0, flushOUT}, {31'b0, e_flush});
      chk("model_npc", nextPcOUT, e_npc);
      chk("model_instr", instruccionOUT, e_ins);
    end
  end

  // Apply one cycle of inputs at the negedge.
  task automatic drive(input bit rst, input bit stl, input bit br, input logic [31:0] tgt,
                       input bit rdy, input logic [31:0] data);
    @(negedge clk);
    reset = rst; stall = stl; branchTaken = br; branchTarget = tgt;
    imemReady = rdy; imemData = data;
  endtask

  initial begin
    // Reset: everything quiet.
    drive(1, 0, 0, 0, 1, 32'h9999_9999);
    #3 chk("rst_req", {31'b0, imemReq}, 32'd0);
    chk("rst_valid", {31'b0, validOUT}, 32'd0);
    drive(1, 0, 0, 0, 0, 0);

    // Three back-to-back deliveries from address 0.
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 1, 32'h1111_0000 + i);
      #3 chk("seq_addr", imemAddr, 32'(i * 4));
      chk("seq_npc", nextPcOUT, 32'(i * 4 + 4));
      chk("seq_valid", {31'b0, validOUT}, 32'd1);
      chk("seq_instr", instruccionOUT, 32'h1111_0000 + i);
    end

    // Redirect to 0x40 coincident with a response (response consumed).
    drive(0, 0, 1, 32'h40, 1, 32'hBAD0_0001);
    #3 chk("br_flush", {31'b0, flushOUT}, 32'd1);
    chk("br_novalid", {31'b0, validOUT}, 32'd0);

    // Redirect while a request to 0x40 is outstanding.
    drive(0, 0, 1, 32'h100, 0, 0);
    #3 chk("disc_flush", {31'b0, flushOUT}, 32'd1);
    chk("disc_addr0", imemAddr, 32'h40);
    drive(0, 0, 0, 0, 0, 0);
    #3 chk("disc_addr1", imemAddr, 32'h40);
    chk("disc_req", {31'b0, imemReq}, 32'd1);
    drive(0, 0, 0, 0, 1, 32'hAAAA_AAAA);
    #3 chk("disc_drop", {31'b0, validOUT}, 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    #3 chk("disc_new_addr", imemAddr, 32'h100);

    // Response arriving during a two-cycle stall.
    drive(0, 1, 0, 0, 1, 32'hDEAD_BEEF);
    #3 chk("stall_valid0", {31'b0, validOUT}, 32'd0);
    chk("stall_req0", {31'b0, imemReq}, 32'd1);
    drive(0, 1, 0, 0, 1, 32'hDEAD_BEEF);
    #3 chk("stall_valid1", {31'b0, validOUT}, 32'd0);
`ifdef FETCH_SKID_EN
    chk("stall_req1", {31'b0, imemReq}, 32'd0);
`else
    chk("stall_addr1", imemAddr, 32'h100);
`endif
    drive(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    #3 chk("stall_instr", instruccionOUT, 32'hDEAD_BEEF);
    chk("stall_npc", nextPcOUT, 32'h104);

    // Redirect beats stall and a ready response.
    drive(0, 1, 1, 32'h200, 1, 32'h5555_5555);
    #3 chk("brst_valid", {31'b0, validOUT}, 32'd0);
    chk("brst_flush", {31'b0, flushOUT}, 32'd1);
    drive(0, 0, 0, 0, 0, 0);
    #3 chk("brst_addr", imemAddr, 32'h200);

    // PC wrap at the top of the address space.
    drive(0, 0, 1, 32'hFFFF_FFFC, 1, 32'h0);
    drive(0, 0, 0, 0, 1, 32'h0000_1234);
    #3 chk("wrap_addr", imemAddr, 32'hFFFF_FFFC);
    chk("wrap_npc", nextPcOUT, 32'h0);
    chk("wrap_valid", {31'b0, validOUT}, 32'd1);
    drive(0, 0, 0, 0, 0, 0);
    #3 chk("wrap_next_addr", imemAddr, 32'h0);

    // Reset in the middle of a discard.
    drive(0, 0, 1, 32'h300, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    #3 chk("rstd_req", {31'b0, imemReq}, 32'd0);
    chk("rstd_npc", nextPcOUT, 32'd0);
    drive(1, 0, 0, 0, 1, 32'h6666_6666);
    #3 chk("rstd_valid", {31'b0, validOUT}, 32'd0);
    chk("rstd_instr", instruccionOUT, 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    #3 chk("rstd_addr", imemAddr, 32'h0);
    chk("rstd_req1", {31'b0, imemReq}, 32'd1);
    drive(0, 0, 0, 0, 1, 32'h0000_0077);
    #3 chk("rstd_deliver", instruccionOUT, 32'h0000_0077);
    chk("rstd_npc1", nextPcOUT, 32'h4);

    // Mixed directed pattern, checked by the model only.
    for (int i = 0; i < 40; i++) begin
      drive(0, (i % 4) == 1, (i % 7) == 5, 32'h1000 + 32'(i * 16),
            (i % 3) != 0, 32'hC0DE_0000 + 32'(i));
    end

    drive(0, 0, 0, 0, 0, 0);
    #3 running = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 stall  in  1  hazard-unit stall; downstream IF_ID is not loading this cycle.
REQ-005 branchTaken  in  1  redirect request from a later stage.
REQ-006 branchTarget  in  32  redirect PC, valid when branchTaken=1.
REQ-007 imemReq  out  1  instruction-memory request.
REQ-008 imemAddr  out  32  request address, word aligned.
REQ-009 imemReady  in  1  memory response strobe; imemData is valid in the same cycle.
REQ-010 imemData  in  32  fetched instruction.
REQ-011 nextPcOUT  out  32  PC+4 of the delivered instruction, to IF_ID nextPcIN.
REQ-012 instruccionOUT  out  32  delivered instruction, to IF_ID instruccionIN.
REQ-013 validOUT  out  1  delivery strobe, drives IF_ID enable.
REQ-014 flushOUT  out  1  drives IF_ID flush.

Function
REQ-015 Internal state: pc (32 bit), held address (32 bit), FSM states REQ, DISCARD and HOLD (HOLD exists only with the configuration macro).
REQ-016 Handshake: once raised, imemReq stays at 1 with imemAddr stable until imemReady=1; a response is consumed only in the cycle imemReady=1.
REQ-017 REQ state: imemReq=1, imemAddr=pc.
REQ-018 REQ with imemReady=1, stall=0 and branchTaken=0: in the same cycle validOUT=1, instruccionOUT=imemData and nextPcOUT=pc+4; pc<=pc+4 at the edge (zero-cycle latency from response to delivery).
REQ-019 REQ with imemReady=1 and stall=1 (macro absent): validOUT=0, pc unchanged, and the request is reissued at the same address next cycle.
REQ-020 branchTaken=1 in any state: flushOUT=1 and validOUT=0 that cycle; pc<=branchTarget.
REQ-021 On branchTaken=1 while the request is outstanding with imemReady=0: the held address is latched, and the FSM moves to DISCARD.
REQ-022 DISCARD state: imemReq=1 and imemAddr=held address until imemReady=1; that response is dropped (validOUT=0), then the FSM returns to REQ.
REQ-023 A further branchTaken=1 in DISCARD updates pc only; the FSM stays in DISCARD.
REQ-024 Priority: reset > branchTaken > stall > normal delivery.
REQ-025 pc+4 arithmetic is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
REQ-026 validOUT=0 and flushOUT=0 whenever no delivery or redirect occurs; instruccionOUT=0 and nextPcOUT=0 when validOUT=0.

Reset
REQ-027 While reset=1: pc<=RESET_PC, FSM<=REQ, skid buffer is emptied, and imemReq, validOUT, flushOUT, nextPcOUT and instruccionOUT are all driven to 0.
REQ-028 A memory response pending at reset is not tracked; in the first cycle after reset, imemReq=1 and imemAddr=RESET_PC.
REQ-029 Reset asserted mid-DISCARD or mid-HOLD abandons that state with no delivery.

Configuration
REQ-030 Macro FETCH_SKID_EN defined: REQ with imemReady=1 and stall=1 captures imemData into a one-entry skid buffer and moves to HOLD with imemReq=0.
REQ-031 In HOLD, with macro defined: validOUT=0 while stall=1; in the first cycle with stall=0, the buffered instruction is delivered with nextPcOUT=pc+4, pc<=pc+4, and the FSM moves to REQ.
REQ-032 branchTaken=1 in HOLD, with macro defined: the buffer is discarded, REQ-020 applies, and the FSM moves directly to REQ.
REQ-033 Macro FETCH_SKID_EN undefined: REQ-019 governs the stall case, and no buffer or HOLD logic is synthesised.

Structure
REQ-034 Shared package pipeline_pkg holds WORD_W=32, PC_STEP=4, INSTR_NOP=32'h0, and the fetch FSM state enum.
REQ-035 One sub-module, fetch_skid_buf (one-entry 32-bit register with a valid flag), is instantiated only under FETCH_SKID_EN.

Verification
REQ-036 Reset, then imemReady=1 on each of 3 cycles with stall=0 -> imemAddr 0, 4, 8; nextPcOUT 4, 8, 12; validOUT=1 each cycle.
REQ-037 pc=0x40, imemReady=0; branchTaken=1 with branchTarget=0x100 -> flushOUT=1; imemAddr remains 0x40 until imemReady; that response is dropped; next imemAddr=0x100.
REQ-038 imemReady=1 with imemData=0xDEADBEEF and stall=1 for 2 cycles -> macro off: validOUT=0 and imemAddr is held; macro on: imemReq=0 during stall, then 0xDEADBEEF delivered on the first stall=0 cycle.
REQ-039 branchTaken=1 coincident with imemReady=1 and stall=1 -> no delivery, flushOUT=1, pc=branchTarget.
REQ-040 pc=0xFFFF_FFFC delivered -> nextPcOUT=0 and the next imemAddr is 0.
REQ-041 reset asserted in DISCARD -> all outputs 0 during reset, then imemAddr=RESET_PC with no stale delivery.
